// File: rtl/clock_divider_multi.sv
// clock_divider_multi: NUM_CH independent programmable clock dividers.
// Each channel emits a square wave (half-period = act_div cycles) and a
// one-cycle tick on every toggle. A divider loaded mid-period is held in a
// shadow register and applied only at the next wrap, so half-periods are
// never truncated.
// Optional feature macro: CLKDIV_SYNC_EN adds sync_in, which restarts every
// enabled channel from phase zero.
module clock_divider_multi #(
    parameter int NUM_CH  = 4,
    parameter int DIV_W   = 32,
    parameter int DEF_DIV = 1
) (
    input  logic                    clk_in,
    input  logic                    reset_n,
    input  logic [NUM_CH-1:0]       enable,
    input  logic [NUM_CH*DIV_W-1:0] divider,
    input  logic [NUM_CH-1:0]       load,
`ifdef CLKDIV_SYNC_EN
    input  logic                    sync_in,
`endif
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       pending
);

    localparam logic [DIV_W-1:0] DEF_VAL = DIV_W'(DEF_DIV);

    // Last counter value of a half-period; a divider of 0 behaves like 1.
    function automatic logic [DIV_W-1:0] last_count(input logic [DIV_W-1:0] div);
        return (div == '0) ? '0 : div - 1'b1;
    endfunction

    logic restart;

`ifdef CLKDIV_SYNC_EN
    assign restart = sync_in;
`else
    assign restart = 1'b0;
`endif

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic [DIV_W-1:0] cnt;
        logic [DIV_W-1:0] act_div;
        logic [DIV_W-1:0] shadow;
        logic [DIV_W-1:0] new_div;
        logic             clk_q;
        logic             tick_q;
        logic             pend_q;
        logic             wrap;

        assign new_div = divider[ch*DIV_W +: DIV_W];
        assign wrap    = (cnt == last_count(act_div));

        // Per-channel counter, output toggle and shadow-divider handoff.
        always_ff @(posedge clk_in or negedge reset_n) begin
            if (!reset_n) begin
                cnt     <= '0;
                act_div <= DEF_VAL;
                shadow  <= DEF_VAL;
                clk_q   <= 1'b0;
                tick_q  <= 1'b0;
                pend_q  <= 1'b0;
            end else if (!enable[ch] || restart) begin
                // Idle or phase restart: park at zero and apply any new value now.
                cnt    <= '0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
                pend_q <= 1'b0;
                if (load[ch]) begin
                    act_div <= new_div;
                    shadow  <= new_div;
                end else if (pend_q) begin
                    act_div <= shadow;
                end
            end else if (wrap) begin
                cnt    <= '0;
                clk_q  <= ~clk_q;
                tick_q <= 1'b1;
                pend_q <= 1'b0;
                if (load[ch]) begin
                    act_div <= new_div;
                    shadow  <= new_div;
                end else if (pend_q) begin
                    act_div <= shadow;
                end
            end else begin
                cnt    <= cnt + 1'b1;
                tick_q <= 1'b0;
                if (load[ch]) begin
                    shadow <= new_div;
                    pend_q <= 1'b1;
                end
            end
        end

        assign clk_out[ch] = clk_q;
        assign tick[ch]    = tick_q;
        assign pending[ch] = pend_q;
    end

endmodule
